// File: rtl/wr_crossbar_arb_pkg.sv
// Shared constants and width helpers for the LSU-to-bank write crossbar.
package wr_crossbar_arb_pkg;

  localparam int DEF_NUM_LSU  = 4;
  localparam int DEF_NUM_BANK = 4;
  localparam int DEF_DATA_W   = 32;

  // Packed request layout, MSB to LSB: {sel, wen, data}.
  function automatic int req_width(input int sel_w, input int data_w);
    return sel_w + 1 + data_w;
  endfunction

  // Bank-side beat layout, MSB to LSB: {wen, data}.
  function automatic int bank_width(input int data_w);
    return 1 + data_w;
  endfunction

endpackage

// File: rtl/wr_crossbar_arb_rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after the pointer,
// and moves the pointer just past the winner when the grant is consumed.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             advance,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] r_ptr;
  logic             w_found;

  // Scan upward from the pointer, modulo N, and take the first request seen.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    w_found   = 1'b0;
    idx       = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(r_ptr) + k) % N;
      if (!w_found && req[idx]) begin
        w_found    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = IDX_W'(idx);
      end
    end
  end

  // Pointer moves to winner+1 only when the grant is actually taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= '0;
    end else if (advance && w_found) begin
      r_ptr <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + IDX_W'(1);
    end
  end

endmodule

// File: rtl/wr_crossbar_arb.sv
// NUM_LSU x NUM_BANK write crossbar with per-bank round-robin arbitration,
// a one-deep registered beat per bank, conflict counting and a sticky
// out-of-range bank-select flag.
module wr_crossbar_arb
  import wr_crossbar_arb_pkg::*;
#(
  parameter int NUM_LSU  = DEF_NUM_LSU,
  parameter int NUM_BANK = DEF_NUM_BANK,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SEL_W    = 2,
  parameter int SRC_W    = 2,
  parameter int CNT_W    = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_LSU-1:0]        lsu_req_valid,
  input  logic [NUM_LSU*SEL_W-1:0]  lsu_req_sel,
  input  logic [NUM_LSU-1:0]        lsu_req_wen,
  input  logic [NUM_LSU*DATA_W-1:0] lsu_req_data,
  output logic [NUM_LSU-1:0]        lsu_req_ready,
  output logic [NUM_BANK-1:0]       bg_valid,
  output logic [NUM_BANK-1:0]       bg_wen,
  output logic [NUM_BANK*DATA_W-1:0] bg_data,
  output logic [NUM_BANK*SRC_W-1:0] bg_src,
  input  logic [NUM_BANK-1:0]       bg_ready,
  output logic [CNT_W-1:0]          conflict_cnt,
  output logic                      sel_err
);

  localparam int W_Q   = req_width(SEL_W, DATA_W);
  localparam int W_D   = bank_width(DATA_W);
  localparam int IDX_W = $clog2(NUM_LSU);

  logic [W_Q-1:0]     w_req_q     [NUM_LSU];
  logic [SEL_W-1:0]   w_sel       [NUM_LSU];
  logic [NUM_LSU-1:0] w_bank_grant[NUM_BANK];
  logic               w_conflict;
  logic               w_sel_bad;
  logic [CNT_W-1:0]   r_conflict_cnt;
  logic               r_sel_err;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  for (genvar i = 0; i < NUM_LSU; i++) begin : g_lsu
    assign w_req_q[i] = {lsu_req_sel[i*SEL_W +: SEL_W], lsu_req_wen[i],
                         lsu_req_data[i*DATA_W +: DATA_W]};
    assign w_sel[i]   = w_req_q[i][W_Q-1 -: SEL_W];
  end

  for (genvar b = 0; b < NUM_BANK; b++) begin : g_bank
    logic [NUM_LSU-1:0] w_cand;
    logic [NUM_LSU-1:0] w_grant;
    logic [IDX_W-1:0]   w_gidx;
    logic               w_slot_free;
    logic               w_fill;
    logic               r_valid;
    logic [W_D-1:0]     r_d;
    logic [SRC_W-1:0]   r_src;

    // Candidates for this bank: valid requests whose select matches it.
    always_comb begin
      w_cand = '0;
      for (int i = 0; i < NUM_LSU; i++) begin
        w_cand[i] = lsu_req_valid[i] && (w_sel[i] == SEL_W'(b));
      end
    end

    assign w_slot_free     = !r_valid || bg_ready[b];
    assign w_fill          = w_slot_free && (|w_cand);
    assign w_bank_grant[b] = w_slot_free ? w_grant : '0;

    rr_arbiter #(.N(NUM_LSU), .IDX_W(IDX_W)) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req      (w_cand),
      .advance  (w_fill),
      .grant    (w_grant),
      .grant_idx(w_gidx)
    );

    // Output beat: load winner on fill, drop valid on drain, hold on stall.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_valid <= 1'b0;
        r_d     <= '0;
        r_src   <= '0;
      end else if (w_fill) begin
        r_valid <= 1'b1;
        r_d     <= w_req_q[w_gidx][W_D-1:0];
        r_src   <= SRC_W'(w_gidx);
      end else if (w_slot_free) begin
        r_valid <= 1'b0;
      end
    end

    assign bg_valid[b]                  = r_valid;
    assign bg_wen[b]                    = r_d[DATA_W];
    assign bg_data[b*DATA_W +: DATA_W]  = r_d[DATA_W-1:0];
    assign bg_src[b*SRC_W +: SRC_W]     = r_src;
  end

  // Each LSU is ready when it won its bank and that bank's slot is free.
  always_comb begin
    lsu_req_ready = '0;
    for (int b = 0; b < NUM_BANK; b++) begin
      lsu_req_ready = lsu_req_ready | w_bank_grant[b];
    end
  end

  // Flag any valid request aimed at a bank that does not exist.
  always_comb begin
    w_sel_bad = 1'b0;
    for (int i = 0; i < NUM_LSU; i++) begin
      if (lsu_req_valid[i] && (int'(w_sel[i]) >= NUM_BANK)) w_sel_bad = 1'b1;
    end
  end

  assign w_conflict = |(lsu_req_valid & ~lsu_req_ready);

  // Saturating conflict counter and sticky select-error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
      r_sel_err      <= 1'b0;
    end else begin
      if (w_conflict) r_conflict_cnt <= sat_inc(r_conflict_cnt);
      if (w_sel_bad)  r_sel_err      <= 1'b1;
    end
  end

  assign conflict_cnt = r_conflict_cnt;
  assign sel_err      = r_sel_err;

endmodule

// File: tb/tb_wr_crossbar_arb.sv
// Bench for wr_crossbar_arb: a 4x4 instance and a 4x3 instance with a 4-bit
// counter share the LSU inputs; a per-cycle model plus directed literals.
module tb_wr_crossbar_arb;
  localparam int NL = 4;
  localparam int DW = 32;
  localparam int SW = 2;
  localparam int RW = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic chk_en = 1'b0;
  logic [NL-1:0]    valid, wen;
  logic [NL*SW-1:0] sel;
  logic [NL*DW-1:0] data;
  logic [3:0]       bg_ready;

  logic [NL-1:0]   a_ready;
  logic [3:0]      a_bv, a_bw;
  logic [4*DW-1:0] a_bd;
  logic [4*RW-1:0] a_bs;
  logic [15:0]     a_cnt;
  logic            a_err;

  logic [NL-1:0]   b_ready;
  logic [2:0]      b_bv, b_bw;
  logic [3*DW-1:0] b_bd;
  logic [3*RW-1:0] b_bs;
  logic [3:0]      b_cnt;
  logic            b_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  wr_crossbar_arb #(.NUM_LSU(4), .NUM_BANK(4), .DATA_W(DW), .SEL_W(SW),
                    .SRC_W(RW), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .lsu_req_valid(valid), .lsu_req_sel(sel),
    .lsu_req_wen(wen), .lsu_req_data(data), .lsu_req_ready(a_ready),
    .bg_valid(a_bv), .bg_wen(a_bw), .bg_data(a_bd), .bg_src(a_bs),
    .bg_ready(bg_ready), .conflict_cnt(a_cnt), .sel_err(a_err));

  wr_crossbar_arb #(.NUM_LSU(4), .NUM_BANK(3), .DATA_W(DW), .SEL_W(SW),
                    .SRC_W(RW), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .lsu_req_valid(valid), .lsu_req_sel(sel),
    .lsu_req_wen(wen), .lsu_req_data(data), .lsu_req_ready(b_ready),
    .bg_valid(b_bv), .bg_wen(b_bw), .bg_data(b_bd), .bg_src(b_bs),
    .bg_ready(bg_ready[2:0]), .conflict_cnt(b_cnt), .sel_err(b_err));

  // Uniform views of both instances for the compare process.
  logic [3:0]      g_rdy [2];
  logic [3:0]      g_bv  [2];
  logic [3:0]      g_bw  [2];
  logic [4*DW-1:0] g_bd  [2];
  logic [4*RW-1:0] g_bs  [2];
  logic [15:0]     g_cnt [2];
  logic            g_err [2];
  assign g_rdy[0] = a_ready;        assign g_rdy[1] = b_ready;
  assign g_bv[0]  = a_bv;           assign g_bv[1]  = {1'b0, b_bv};
  assign g_bw[0]  = a_bw;           assign g_bw[1]  = {1'b0, b_bw};
  assign g_bd[0]  = a_bd;           assign g_bd[1]  = {32'h0, b_bd};
  assign g_bs[0]  = a_bs;           assign g_bs[1]  = {2'b0, b_bs};
  assign g_cnt[0] = a_cnt;          assign g_cnt[1] = {12'h0, b_cnt};
  assign g_err[0] = a_err;          assign g_err[1] = b_err;

  // Model state: one held beat per bank, a rotation pointer per bank.
  int          NB   [2] = '{4, 3};
  int          CMAX [2] = '{65535, 15};
  bit          mv   [2][4];
  bit          mw   [2][4];
  logic [31:0] md   [2][4];
  int          ms   [2][4];
  int          mp   [2][4];
  int          mc   [2];
  bit          me   [2];

  function automatic int sel_of(input int i);
    logic [SW-1:0] s;
    s = sel[i*SW +: SW];
    return int'(s);
  endfunction

  function automatic logic [31:0] data_of(input int i);
    return data[i*DW +: DW];
  endfunction

  function automatic void model_reset();
    for (int m = 0; m < 2; m++) begin
      for (int b = 0; b < 4; b++) begin
        mv[m][b] = 0; mw[m][b] = 0; md[m][b] = '0; ms[m][b] = 0; mp[m][b] = 0;
      end
      mc[m] = 0;
      me[m] = 0;
    end
  endfunction

  // LSU i is accepted if it is the first requester of its bank counting up
  // from that bank's pointer, and the bank is empty or draining.
  function automatic logic [3:0] exp_ready(input int m);
    logic [3:0] r;
    int s, w, j;
    r = '0;
    for (int i = 0; i < NL; i++) begin
      s = sel_of(i);
      if (valid[i] && s < NB[m]) begin
        w = -1;
        for (int k = 0; k < NL; k++) begin
          j = (mp[m][s] + k) % NL;
          if (w < 0 && valid[j] && sel_of(j) == s) w = j;
        end
        if (w == i && (!mv[m][s] || bg_ready[s])) r[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic void model_step(input int m);
    logic [3:0] r;
    bit found, anyc;
    r = exp_ready(m);
    anyc = 0;
    for (int b = 0; b < NB[m]; b++) begin
      if (!mv[m][b] || bg_ready[b]) begin
        found = 0;
        for (int i = 0; i < NL; i++) begin
          if (r[i] && sel_of(i) == b) begin
            found = 1;
            mv[m][b] = 1; mw[m][b] = wen[i]; md[m][b] = data_of(i);
            ms[m][b] = i; mp[m][b] = (i + 1) % NL;
          end
        end
        if (!found) mv[m][b] = 0;
      end
    end
    for (int i = 0; i < NL; i++) begin
      if (valid[i] && !r[i]) anyc = 1;
      if (valid[i] && sel_of(i) >= NB[m]) me[m] = 1;
    end
    if (anyc && mc[m] < CMAX[m]) mc[m] = mc[m] + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else for (int m = 0; m < 2; m++) model_step(m);
  end

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare against the model, mid-cycle away from the edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int m = 0; m < 2; m++) begin
        chk($sformatf("m%0d.ready", m), 64'(g_rdy[m]), 64'(exp_ready(m)));
        for (int b = 0; b < NB[m]; b++) begin
          chk($sformatf("m%0d.bg_valid[%0d]", m, b), 64'(g_bv[m][b]), 64'(mv[m][b]));
          chk($sformatf("m%0d.bg_wen[%0d]", m, b), 64'(g_bw[m][b]), 64'(mw[m][b]));
          chk($sformatf("m%0d.bg_data[%0d]", m, b), 64'(g_bd[m][b*DW +: DW]), 64'(md[m][b]));
          chk($sformatf("m%0d.bg_src[%0d]", m, b), 64'(g_bs[m][b*RW +: RW]), 64'(ms[m][b]));
        end
        chk($sformatf("m%0d.conflict_cnt", m), 64'(g_cnt[m]), 64'(mc[m]));
        chk($sformatf("m%0d.sel_err", m), 64'(g_err[m]), 64'(me[m]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    valid = '0; wen = '0; sel = '0; data = '0;
  endtask

  task automatic setl(input int i, input logic s_valid, input int s_sel,
                      input logic s_wen, input logic [31:0] s_data);
    valid[i] = s_valid;
    sel[i*SW +: SW] = SW'(s_sel);
    wen[i] = s_wen;
    data[i*DW +: DW] = s_data;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle();
    bg_ready = 4'hF;
    repeat (2) tick();
    rst_n = 1'b1;
  endtask

  initial begin
    model_reset();
    idle();
    bg_ready = 4'hF;
    #2 rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    chk_en = 1'b1;

    // Reset state
    chk("reset.a_bg_valid", 64'(a_bv), 64'h0);
    chk("reset.b_bg_valid", 64'(b_bv), 64'h0);
    chk("reset.a_cnt", 64'(a_cnt), 64'h0);
    chk("reset.a_sel_err", 64'(a_err), 64'h0);

    // Four LSUs to four distinct banks
    for (int i = 0; i < NL; i++) setl(i, 1'b1, i, 1'b1, 32'hA0 + i);
    #1;
    chk("par.a_ready", 64'(a_ready), 64'hF);
    chk("par.b_ready", 64'(b_ready), 64'h7);
    tick();
    idle();
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("par.a_data[%0d]", b), 64'(a_bd[b*DW +: DW]), 64'hA0 + 64'(b));
      chk($sformatf("par.a_src[%0d]", b), 64'(a_bs[b*RW +: RW]), 64'(b));
    end
    chk("par.a_cnt", 64'(a_cnt), 64'h0);
    chk("par.b_sel_err", 64'(b_err), 64'h1);
    chk("par.b_cnt", 64'(b_cnt), 64'h1);
    tick();

    // All four contend for bank 2
    do_reset();
    for (int i = 0; i < NL; i++) setl(i, 1'b1, 2, 1'b1, 32'hB0 + i);
    for (int k = 0; k < 8; k++) begin
      #1;
      chk($sformatf("rr.a_ready[%0d]", k), 64'(a_ready), 64'(1 << (k % 4)));
      tick();
      chk($sformatf("rr.a_src2[%0d]", k), 64'(a_bs[2*RW +: RW]), 64'(k % 4));
      chk($sformatf("rr.a_data2[%0d]", k), 64'(a_bd[2*DW +: DW]), 64'hB0 + 64'(k % 4));
    end
    chk("rr.a_cnt", 64'(a_cnt), 64'd8);
    chk("rr.b_cnt", 64'(b_cnt), 64'd8);
    idle();
    tick();

    // Backpressure on bank 0
    do_reset();
    setl(1, 1'b1, 0, 1'b1, 32'h11);
    bg_ready = 4'b1110;
    #1;
    chk("bp.first_ready", 64'(a_ready), 64'h2);
    tick();
    setl(1, 1'b1, 0, 1'b0, 32'h22);
    for (int k = 0; k < 5; k++) begin
      #1;
      chk($sformatf("bp.stall_ready[%0d]", k), 64'(a_ready), 64'h0);
      chk($sformatf("bp.stall_data[%0d]", k), 64'(a_bd[0 +: DW]), 64'h11);
      tick();
    end
    bg_ready = 4'hF;
    #1;
    chk("bp.release_ready", 64'(a_ready), 64'h2);
    tick();
    idle();
    chk("bp.nobubble_valid", 64'(a_bv[0]), 64'h1);
    chk("bp.nobubble_data", 64'(a_bd[0 +: DW]), 64'h22);
    chk("bp.nobubble_wen", 64'(a_bw[0]), 64'h0);
    tick();
    chk("bp.drain_valid", 64'(a_bv[0]), 64'h0);
    chk("bp.drain_hold", 64'(a_bd[0 +: DW]), 64'h22);

    // Out-of-range select on the 3-bank instance
    do_reset();
    setl(0, 1'b1, 3, 1'b1, 32'h30);
    setl(1, 1'b1, 1, 1'b1, 32'h31);
    #1;
    chk("oor.b_ready", 64'(b_ready), 64'h2);
    chk("oor.a_ready", 64'(a_ready), 64'h3);
    tick();
    chk("oor.b_sel_err", 64'(b_err), 64'h1);
    chk("oor.a_sel_err", 64'(a_err), 64'h0);
    chk("oor.b_bv", 64'(b_bv), 64'h2);
    chk("oor.b_data1", 64'(b_bd[1*DW +: DW]), 64'h31);
    idle();
    repeat (3) tick();
    chk("oor.b_sel_err_sticky", 64'(b_err), 64'h1);

    // Counter saturation
    do_reset();
    for (int i = 0; i < NL; i++) setl(i, 1'b1, 0, 1'b1, 32'hC0 + i);
    repeat (20) tick();
    chk("sat.b_cnt", 64'(b_cnt), 64'd15);
    chk("sat.a_cnt", 64'(a_cnt), 64'd20);
    idle();
    tick();

    // Asynchronous reset mid-stall
    do_reset();
    setl(1, 1'b1, 1, 1'b1, 32'h61);
    bg_ready = 4'b1101;
    #1;
    chk("ar.first_ready", 64'(a_ready), 64'h2);
    tick();
    setl(1, 1'b1, 1, 1'b1, 32'h62);
    repeat (2) tick();
    chk("ar.held_valid", 64'(a_bv[1]), 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.valid_cleared", 64'(a_bv), 64'h0);
    chk("ar.data_cleared", 64'(a_bd[1*DW +: DW]), 64'h0);
    idle();
    bg_ready = 4'hF;
    @(posedge clk);
    #3 rst_n = 1'b1;
    setl(0, 1'b1, 1, 1'b1, 32'h70);
    setl(2, 1'b1, 1, 1'b1, 32'h72);
    #1;
    chk("ar.restart_ready", 64'(a_ready), 64'h1);
    tick();
    chk("ar.restart_src", 64'(a_bs[1*RW +: RW]), 64'h0);
    chk("ar.restart_data", 64'(a_bd[1*DW +: DW]), 64'h70);
    idle();
    repeat (2) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
